// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with byte-enabled writes, optional write-to-read
// bypass, optional hardwired zero entry and a self-sequenced clear engine.
module regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    output logic                    o_busy,
    input  logic                    i_wr_en,
    input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_wr_be,
    input  logic [ADDR_WIDTH-1:0]   i_rd0_addr,
    output logic [DATA_WIDTH-1:0]   o_rd0_data,
    input  logic [ADDR_WIDTH-1:0]   i_rd1_addr,
    output logic [DATA_WIDTH-1:0]   o_rd1_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [ADDR_WIDTH-1:0]   clr_cnt_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    busy;
    logic                    wr_fire;
    logic [DATA_WIDTH-1:0]   rd0_next;
    logic [DATA_WIDTH-1:0]   rd1_next;

    assign busy    = (state == CLEAR);
    assign o_busy  = busy;
    assign wr_fire = !busy && i_wr_en && !((ZERO_REG != 0) && (i_wr_addr == '0));

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Clear walks every entry once; the last entry is reached when the counter is all ones.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            IDLE: begin
                if (i_clear) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (&clr_cnt) state_next = IDLE;
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (busy) begin
                mem[clr_cnt] <= '0;
            end else if (wr_fire) begin
                for (int k = 0; k < NB; k++) begin
                    if (i_wr_be[k]) mem[i_wr_addr][8*k +: 8] <= i_wr_data[8*k +: 8];
                end
            end
        end
    end

    // Both ports share one selection rule; the bypass presents the post-write value.
    always_comb begin
        rd0_next = mem[i_rd0_addr];
        rd1_next = mem[i_rd1_addr];
        if ((BYPASS != 0) && i_wr_en && (i_wr_addr == i_rd0_addr))
            rd0_next = merge_bytes(mem[i_rd0_addr], i_wr_data, i_wr_be);
        if ((BYPASS != 0) && i_wr_en && (i_wr_addr == i_rd1_addr))
            rd1_next = merge_bytes(mem[i_rd1_addr], i_wr_data, i_wr_be);
        if ((ZERO_REG != 0) && (i_rd0_addr == '0)) rd0_next = '0;
        if ((ZERO_REG != 0) && (i_rd1_addr == '0)) rd1_next = '0;
        if (busy) begin
            rd0_next = '0;
            rd1_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_rd0_data <= '0;
            o_rd1_data <= '0;
        end else begin
            o_rd0_data <= rd0_next;
            o_rd1_data <= rd1_next;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: a reference model predicts every read and the
// busy flag, expectations are queued at drive time and compared after the clock edge.
module tb_regfile_2r1w;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_clear = 1'b0;
    logic         o_busy;
    logic         i_wr_en = 1'b0;
    logic [4:0]   i_wr_addr = '0;
    logic [W-1:0] i_wr_data = '0;
    logic [3:0]   i_wr_be = '0;
    logic [4:0]   i_rd0_addr = '0;
    logic [W-1:0] o_rd0_data;
    logic [4:0]   i_rd1_addr = '0;
    logic [W-1:0] o_rd1_data;

    regfile_2r1w dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (i_clear),
        .o_busy     (o_busy),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_wr_be    (i_wr_be),
        .i_rd0_addr (i_rd0_addr),
        .o_rd0_data (o_rd0_data),
        .i_rd1_addr (i_rd1_addr),
        .o_rd1_data (o_rd1_data)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_mem [32];
    logic         m_busy = 1'b1;
    int           m_cnt = 0;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] old_v, input logic [W-1:0] new_v,
                                           input logic [3:0] be);
        logic [W-1:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    function automatic logic [W-1:0] model_rd(input logic [4:0] a, input logic we,
                                              input logic [4:0] wa, input logic [W-1:0] wd,
                                              input logic [3:0] be);
        if (a == 5'd0) return '0;
        if (we && wa == a) return merge(m_mem[a], wd, be);
        return m_mem[a];
    endfunction

    // driver: one clock of stimulus, prediction, and comparison
    task automatic step(input logic clr, input logic we, input logic [4:0] wa,
                        input logic [W-1:0] wd, input logic [3:0] be,
                        input logic [4:0] a0, input logic [4:0] a1);
        i_clear = clr; i_wr_en = we; i_wr_addr = wa; i_wr_data = wd; i_wr_be = be;
        i_rd0_addr = a0; i_rd1_addr = a1;
        if (!rst_n || m_busy) begin
            exp_q.push_back('0);
            exp_q.push_back('0);
        end else begin
            exp_q.push_back(model_rd(a0, we, wa, wd, be));
            exp_q.push_back(model_rd(a1, we, wa, wd, be));
        end
        if (!rst_n) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (m_busy) begin
            m_mem[m_cnt] = '0;
            if (m_cnt == 31) m_busy = 1'b0;
            m_cnt++;
        end else begin
            if (we && wa != 5'd0) m_mem[wa] = merge(m_mem[wa], wd, be);
            if (clr) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
        exp_q.push_back({31'b0, m_busy});
        @(posedge clk);
        #1;
        check("rd0", o_rd0_data, exp_q.pop_front());
        check("rd1", o_rd1_data, exp_q.pop_front());
        check("busy", {31'b0, o_busy}, exp_q.pop_front());
    endtask

    task automatic rand_step(input logic we, input logic clr);
        step(clr, we, 5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    endtask

    // counts cycles until busy drops, bounded
    task automatic busy_len(input logic wr_traffic, input int clr_at, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            rand_step(wr_traffic, (i == clr_at));
            n++;
            if (!o_busy) break;
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, '0, '0, 5'(2*i), 5'(31 - 2*i));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;

        // T1: reset then automatic clear
        rst_n = 1'b0;
        repeat (3) step(1'b0, 1'b0, '0, '0, '0, 5'd3, 5'd4);
        rst_n = 1'b1;
        busy_len(1'b0, -1, n);
        check("t1_busy_len", n, 32);
        read_all();

        // T2: byte enables
        step(1'b0, 1'b1, 5'd5, 32'hAABBCCDD, 4'hF, 5'd1, 5'd2);
        step(1'b0, 1'b1, 5'd5, 32'h11223344, 4'b0101, 5'd6, 5'd7);
        step(1'b0, 1'b0, '0, '0, '0, 5'd5, 5'd5);
        check("t2_be_rd0", o_rd0_data, 32'hAA22CC44);
        check("t2_be_rd1", o_rd1_data, 32'hAA22CC44);
        step(1'b0, 1'b1, 5'd5, 32'hFFFFFFFF, 4'h0, 5'd5, 5'd0);
        check("t2_be_zero", o_rd0_data, 32'hAA22CC44);

        // T3: same-cycle bypass
        step(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 4'hF, 5'd7, 5'd3);
        check("t3_bypass", o_rd0_data, 32'hDEADBEEF);

        // T4: hardwired zero entry
        step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0);
        step(1'b0, 1'b0, '0, '0, '0, 5'd0, 5'd0);
        check("t4_zero_rd0", o_rd0_data, 32'h0);
        check("t4_zero_rd1", o_rd1_data, 32'h0);

        // T5: fill, clear with writes and a second clear mid-way
        for (int i = 0; i < 32; i++)
            step(1'b0, 1'b1, 5'(i), $urandom | 32'h1, 4'hF, 5'(i), 5'($urandom_range(0, 31)));
        step(1'b1, 1'b0, '0, '0, '0, 5'd9, 5'd10);
        busy_len(1'b1, 10, n);
        check("t5_busy_len", n, 32);
        read_all();

        // T6: reset at clear cycle 10, then random traffic
        step(1'b1, 1'b0, '0, '0, '0, 5'd1, 5'd2);
        repeat (9) rand_step(1'b1, 1'b0);
        rst_n = 1'b0;
        repeat (2) rand_step(1'b1, 1'b0);
        rst_n = 1'b1;
        busy_len(1'b1, -1, n);
        check("t6_busy_len", n, 32);
        for (int i = 0; i < 400; i++) rand_step(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
        repeat (40) rand_step(1'b0, 1'b0);
        read_all();

        check("q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
